// File: rtl/recv_ctrl.sv
// UART 8N1 receiver with an in-order ID string matcher ("hitsz2024311278").
// Each correctly framed byte is presented on rx_data with a 1-cycle rx_valid
// strobe; a low stop bit raises a 1-cycle frame_err and discards the byte.
module recv_ctrl #(
  parameter int unsigned CYCLES_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       match,
  output logic [3:0] char_cnt
);

  localparam int unsigned CNT_W = (CYCLES_PER_BIT > 2) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [3:0]       PTR_LAST = 4'd14;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // synchroniser / edge detect
  logic r_sync1, r_sync2, r_sync3;
  logic w_line, w_fall;

  // receiver state
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [7:0]       r_rx_data, w_rx_data_nxt;
  logic             r_rx_valid, w_rx_valid_nxt;
  logic             r_frame_err, w_frame_err_nxt;

  // string matcher
  logic [3:0] r_ptr, w_ptr_nxt;
  logic       r_match, w_match_nxt;
  logic [7:0] w_rom_char;

  assign w_line = r_sync2;
  assign w_fall = r_sync3 & ~r_sync2;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Receiver next-state: every sample is taken at the middle of its bit.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt   = S_START;
          w_bit_cnt_nxt = '0;
        end
      end
      S_START: begin
        if (r_bit_cnt == BIT_HALF) begin
          if (w_line) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt   = S_DATA;
            w_bit_cnt_nxt = '0;
            w_bit_idx_nxt = '0;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_bit_cnt == BIT_LAST) begin
          w_shift_nxt[r_bit_idx] = w_line;
          w_bit_cnt_nxt          = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      S_STOP: begin
        // Leave at stop-bit mid so a back-to-back start edge is not missed.
        if (r_bit_cnt == BIT_LAST) begin
          w_state_nxt   = S_IDLE;
          w_bit_cnt_nxt = '0;
          if (w_line) begin
            w_rx_data_nxt  = r_shift;
            w_rx_valid_nxt = 1'b1;
          end else begin
            w_frame_err_nxt = 1'b1;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ID string ROM indexed by the match pointer.
  always_comb begin
    w_rom_char = 8'h00;
    unique case (r_ptr)
      4'd0:    w_rom_char = 8'h68; // h
      4'd1:    w_rom_char = 8'h69; // i
      4'd2:    w_rom_char = 8'h74; // t
      4'd3:    w_rom_char = 8'h73; // s
      4'd4:    w_rom_char = 8'h7A; // z
      4'd5:    w_rom_char = 8'h32; // 2
      4'd6:    w_rom_char = 8'h30; // 0
      4'd7:    w_rom_char = 8'h32; // 2
      4'd8:    w_rom_char = 8'h34; // 4
      4'd9:    w_rom_char = 8'h33; // 3
      4'd10:   w_rom_char = 8'h31; // 1
      4'd11:   w_rom_char = 8'h31; // 1
      4'd12:   w_rom_char = 8'h32; // 2
      4'd13:   w_rom_char = 8'h37; // 7
      4'd14:   w_rom_char = 8'h38; // 8
      default: w_rom_char = 8'h00;
    endcase
  end

  // Matcher next-state: advances only on a valid byte; 'h' is unique so it restarts at 1.
  always_comb begin
    w_ptr_nxt   = r_ptr;
    w_match_nxt = 1'b0;
    if (r_frame_err) begin
      w_ptr_nxt = '0;
    end else if (r_rx_valid) begin
      if (r_rx_data == w_rom_char) begin
        if (r_ptr == PTR_LAST) begin
          w_ptr_nxt   = '0;
          w_match_nxt = 1'b1;
        end else begin
          w_ptr_nxt = r_ptr + 4'd1;
        end
      end else if (r_rx_data == 8'h68) begin
        w_ptr_nxt = 4'd1;
      end else begin
        w_ptr_nxt = '0;
      end
    end
  end

  // Matcher registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr   <= '0;
      r_match <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_match <= w_match_nxt;
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign match     = r_match;
  assign char_cnt  = r_ptr;

endmodule

// File: tb/tb_recv_ctrl.sv
// Directed bench for recv_ctrl at 16 clocks per bit.
module tb_recv_ctrl;

  localparam int unsigned CPB = 16;

  logic       clk;
  logic       rst;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       match;
  logic [3:0] char_cnt;

  recv_ctrl #(.CYCLES_PER_BIT(CPB)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .match     (match),
    .char_cnt  (char_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // monitor state
  int         n_valid = 0;
  int         n_ferr = 0;
  int         n_match = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_valid_cyc = 0;
  int         match_cyc = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr = 1'b0;
  logic [7:0] byte_q[$];
  logic [3:0] cnt_q[$];

  logic [7:0] id_str[15] = '{8'h68, 8'h69, 8'h74, 8'h73, 8'h7A, 8'h32, 8'h30, 8'h32,
                             8'h34, 8'h33, 8'h31, 8'h31, 8'h32, 8'h37, 8'h38};

  // Observe DUT on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (prev_valid) cnt_q.push_back(char_cnt);
    if (rx_valid) begin
      n_valid <= n_valid + 1;
      byte_q.push_back(rx_data);
      last_valid_cyc <= cyc;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (match) begin
      n_match <= n_match + 1;
      match_cyc <= cyc;
    end
    if ((rx_valid && prev_valid) || (frame_err && prev_ferr) || (rx_valid && frame_err))
      n_bad <= n_bad + 1;
    prev_valid <= rx_valid;
    prev_ferr  <= frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int unsigned i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int v0, f0, m0, b0, c0, bad0;

  task automatic snap();
    @(negedge clk);
    #1;
    v0 = n_valid; f0 = n_ferr; m0 = n_match;
    b0 = byte_q.size(); c0 = cnt_q.size(); bad0 = n_bad;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, 32'(rx_data), 32'h0);
    check({tag, "_valid"}, 32'(rx_valid), 32'h0);
    check({tag, "_ferr"}, 32'(frame_err), 32'h0);
    check({tag, "_match"}, 32'(match), 32'h0);
    check({tag, "_cnt"}, 32'(char_cnt), 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    check_zero("rst");
    rst = 1'b1;
    idle(2 * CPB);

    // 1: single 'h'
    snap();
    send_byte(8'h68, 1'b1);
    idle(2 * CPB);
    check("t1_nvalid", 32'(n_valid - v0), 32'd1);
    if (byte_q.size() > b0) check("t1_data", 32'(byte_q[b0]), 32'h68);
    else check("t1_data_missing", 32'(byte_q.size()), 32'(b0 + 1));
    check("t1_cnt", 32'(char_cnt), 32'd1);
    check("t1_ferr", 32'(n_ferr - f0), 32'd0);
    check("t1_pulse", 32'(n_bad - bad0), 32'd0);

    // 2: short low glitch
    snap();
    uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(3 * CPB);
    check("t2_nvalid", 32'(n_valid - v0), 32'd0);
    check("t2_ferr", 32'(n_ferr - f0), 32'd0);
    check("t2_cnt", 32'(char_cnt), 32'd1);

    // 3: framing error on 0x41
    snap();
    send_byte(8'h41, 1'b0);
    idle(2 * CPB);
    check("t3_ferr", 32'(n_ferr - f0), 32'd1);
    check("t3_nvalid", 32'(n_valid - v0), 32'd0);
    check("t3_data", 32'(rx_data), 32'h68);
    check("t3_cnt", 32'(char_cnt), 32'd0);
    check("t3_pulse", 32'(n_bad - bad0), 32'd0);

    // 4: full string back-to-back
    snap();
    for (int i = 0; i < 15; i++) send_byte(id_str[i], 1'b1);
    idle(2 * CPB);
    check("t4_nvalid", 32'(n_valid - v0), 32'd15);
    check("t4_nmatch", 32'(n_match - m0), 32'd1);
    check("t4_match_lat", 32'(match_cyc - last_valid_cyc), 32'd1);
    check("t4_pulse", 32'(n_bad - bad0), 32'd0);
    if (byte_q.size() >= b0 + 15 && cnt_q.size() >= c0 + 15) begin
      for (int i = 0; i < 15; i++) begin
        check($sformatf("t4_byte%0d", i), 32'(byte_q[b0 + i]), 32'(id_str[i]));
        check($sformatf("t4_cnt%0d", i), 32'(cnt_q[c0 + i]), (i == 14) ? 32'd0 : 32'(i + 1));
      end
    end else begin
      check("t4_qsize", 32'(byte_q.size()), 32'(b0 + 15));
    end

    // 5: "hith", then the string with a leading 'x'
    snap();
    send_byte(8'h68, 1'b1);
    send_byte(8'h69, 1'b1);
    send_byte(8'h74, 1'b1);
    send_byte(8'h68, 1'b1);
    idle(CPB);
    if (cnt_q.size() >= c0 + 4) begin
      check("t5_cnt0", 32'(cnt_q[c0]), 32'd1);
      check("t5_cnt1", 32'(cnt_q[c0 + 1]), 32'd2);
      check("t5_cnt2", 32'(cnt_q[c0 + 2]), 32'd3);
      check("t5_cnt3", 32'(cnt_q[c0 + 3]), 32'd1);
    end else begin
      check("t5_qsize", 32'(cnt_q.size()), 32'(c0 + 4));
    end
    snap();
    send_byte(8'h78, 1'b1);
    for (int i = 1; i < 15; i++) send_byte(id_str[i], 1'b1);
    idle(2 * CPB);
    check("t5_nvalid", 32'(n_valid - v0), 32'd15);
    check("t5_nmatch", 32'(n_match - m0), 32'd0);
    check("t5_cnt_end", 32'(char_cnt), 32'd0);

    // 6: reset during data bit 4 of 'i' after 'h'
    snap();
    send_byte(8'h68, 1'b1);
    idle(CPB);
    check("t6_cnt_h", 32'(char_cnt), 32'd1);
    drive_bit(1'b0);
    for (int unsigned i = 0; i < 4; i++) drive_bit(1'(8'h69 >> i));
    uart_rx = 1'b0;  // bit 4 of 0x69
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("t6_rst");
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    idle(2 * CPB);
    check("t6_nvalid_abort", 32'(n_valid - v0), 32'd1);
    snap();
    for (int i = 0; i < 15; i++) send_byte(id_str[i], 1'b1);
    idle(2 * CPB);
    check("t6_nvalid", 32'(n_valid - v0), 32'd15);
    check("t6_nmatch", 32'(n_match - m0), 32'd1);
    check("t6_ferr", 32'(n_ferr - f0), 32'd0);
    check("t6_cnt_end", 32'(char_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
